scratch_vtiming: RTL
====================

Name: scratch_vtiming

Overview:
- Parametrised video timing generator for the Scratch core.
- Derives the 2x-pixel and pixel clock enables from the 48 MHz system clock.
- Runs horizontal and vertical raster counters and produces sync, raw blanking and pixel-delayed blanking.
- Registers the RGB from the pixel pipeline, blanking it outside the visible area; sits between the game's video logic and the frame output.

Parameters:
- PXL_DIV, 8, clk cycles per pixel; must be even and at least 4 (48 MHz / 8 = 6 MHz).
- H_TOTAL, 384, pixels per line.
- H_ACTIVE, 256, visible pixels per line, starting at hpos 0.
- HS_START, 288, hpos where HS asserts.
- HS_LEN, 32, HS width in pixels.
- V_TOTAL, 264, lines per frame.
- V_ACTIVE, 224, visible lines per frame, starting at vpos 0.
- VS_START, 240, vpos where VS asserts.
- VS_LEN, 8, VS width in lines.
- BLANK_DLY, 2, pixel delay applied to LHBL_dly/LVBL_dly (0..15).
- CW, 4, bits per colour channel.

Ports:
- clk  in  1  system clock, 48 MHz
- rst  in  1  synchronous active-high reset
- pxl2_cen  out  1  2x-pixel clock enable
- pxl_cen  out  1  pixel clock enable
- hpos  out  9  current horizontal pixel count
- vpos  out  9  current line count
- LHBL  out  1  horizontal active (1 = visible), undelayed
- LVBL  out  1  vertical active (1 = visible), undelayed
- LHBL_dly  out  1  LHBL delayed BLANK_DLY pixels
- LVBL_dly  out  1  LVBL delayed BLANK_DLY pixels
- HS  out  1  horizontal sync, active high
- VS  out  1  vertical sync, active high
- frame  out  1  one-pixel strobe at start of frame
- pxl_red  in  CW  colour from pixel pipeline
- pxl_green  in  CW
- pxl_blue  in  CW
- red  out  CW  registered colour output
- green  out  CW
- blue  out  CW

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high: sampled on a clk rising edge, and it wins over all other activity.
- Reset values: internal divider cnt = 0, hpos = 0, vpos = 0. Every output is 0, including HS, VS, blanking, frame, colours and both enables. The delay line clears to 0.
- Divider: each non-reset edge, cnt <= (cnt == PXL_DIV-1) ? 0 : cnt+1.
  - pxl_cen is registered and is 1 for exactly one cycle per PXL_DIV cycles. It first rises in cycle PXL_DIV after rst falls, i.e. it is high while cnt == PXL_DIV-1.
  - pxl2_cen is high while cnt == PXL_DIV-1 or cnt == PXL_DIV/2-1. It is therefore coincident with every pxl_cen pulse, plus one pulse midway between.
- Raster: all raster state updates only on edges where pxl_cen is 1.
  - hpos <= (hpos == H_TOTAL-1) ? 0 : hpos+1.
  - When hpos wraps, vpos <= (vpos == V_TOTAL-1) ? 0 : vpos+1.
- Outputs are registered on the same pxl_cen edge from the next-state counters, so they are consistent with hpos/vpos:
  - LHBL = (hpos < H_ACTIVE); LVBL = (vpos < V_ACTIVE).
  - HS = 1 for hpos in [HS_START, HS_START+HS_LEN).
  - VS = 1 for vpos in [VS_START, VS_START+VS_LEN). VS changes together with hpos = 0.
  - frame = 1 for the pixel where hpos = 0 and vpos = 0, i.e. PXL_DIV clk cycles.
- Sync windows must not wrap past the total (HS_START+HS_LEN <= H_TOTAL, VS_START+VS_LEN <= V_TOTAL). Violating parameters are a synthesis-time error via a generate-time check.
- Delay line: a BLANK_DLY-deep shift register advanced on pxl_cen carries {LHBL, LVBL} to LHBL_dly/LVBL_dly. With BLANK_DLY = 0 the delayed outputs equal the undelayed ones.
- Colour: on each pxl_cen edge, red/green/blue <= (LHBL_dly & LVBL_dly) ? pxl_* : 0. The blanking term uses the delayed values that will be current after this edge. Colour is held between enables.
- Mid-frame reset returns everything to the reset state on the next edge. The first pixel after reset is hpos 0, vpos 0, with frame asserted.
- Counter widths are fixed at 9 bits; H_TOTAL and V_TOTAL are at most 512.

Optional Feature:
- Macro SCRATCH_VTIMING_PATTERN_EN.
- When defined: adds input `pattern` (1 bit).
  - While pattern = 1, pxl_* inputs are ignored and colour is 8 vertical bars selected by hpos[7:5].
  - Bar n drives red = {CW{n[2]}}, green = {CW{n[1]}}, blue = {CW{n[0]}}, still blanked as above.
  - pattern changes take effect on the next pxl_cen edge.
- When not defined: the port is absent and colour always comes from pxl_*.

Test Plan:
- Default parameters, release reset → first pxl_cen in cycle 8. pxl2_cen is high in cycles 4 and 8, then every 4 cycles. pxl_cen repeats every 8 cycles.
- Run one full frame → frame strobe repeats every 384*264*8 = 811008 clk cycles. hpos spans 0..383 and vpos spans 0..263 with no skipped values.
- Line check → LHBL is high for exactly 256 pixels per line. HS is high for hpos 288..319 (32 pixels). LVBL is high for vpos 0..223. VS is high for vpos 240..247.
- pxl_red = 4'hF constant, BLANK_DLY = 2 → red goes to 0 two pixels after LHBL falls and back to F two pixels after LHBL rises. red is 0 on all lines with vpos >= 226.
- Assert rst for one cycle at hpos 100, vpos 50 → next edge all outputs are 0. The first subsequent pixel is hpos 0, vpos 0 with frame = 1.
- Macro defined, pattern = 1 → at hpos 96..127 (bar 3): red 0, green F, blue F. With pattern = 0: output follows pxl_* on the next pixel.

Source files
------------

// File: rtl/scratch_vtiming_if.sv
// rtl/scratch_vtiming_if.sv - video timing and pixel bus for scratch_vtiming
// Purpose: groups the pixel-pipeline colour inputs and the generated timing/colour outputs.
// master: timing generator side. Drives pxl2_cen, pxl_cen, hpos, vpos, LHBL, LVBL,
//         LHBL_dly, LVBL_dly, HS, VS, frame, red, green, blue.
//         Takes pxl_red, pxl_green, pxl_blue, and pattern when SCRATCH_VTIMING_PATTERN_EN is defined.
// slave:  game video logic / frame output side, with the opposite directions.
interface scratch_vtiming_if #(
  parameter int CW = 4
);
  logic          pxl2_cen;
  logic          pxl_cen;
  logic [8:0]    hpos;
  logic [8:0]    vpos;
  logic          LHBL;
  logic          LVBL;
  logic          LHBL_dly;
  logic          LVBL_dly;
  logic          HS;
  logic          VS;
  logic          frame;
  logic [CW-1:0] pxl_red;
  logic [CW-1:0] pxl_green;
  logic [CW-1:0] pxl_blue;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
`ifdef SCRATCH_VTIMING_PATTERN_EN
  logic          pattern;
`endif

  modport master (
`ifdef SCRATCH_VTIMING_PATTERN_EN
    input  pattern,
`endif
    input  pxl_red, pxl_green, pxl_blue,
    output pxl2_cen, pxl_cen, hpos, vpos, LHBL, LVBL, LHBL_dly, LVBL_dly,
           HS, VS, frame, red, green, blue
  );

  modport slave (
`ifdef SCRATCH_VTIMING_PATTERN_EN
    output pattern,
`endif
    output pxl_red, pxl_green, pxl_blue,
    input  pxl2_cen, pxl_cen, hpos, vpos, LHBL, LVBL, LHBL_dly, LVBL_dly,
           HS, VS, frame, red, green, blue
  );
endinterface

// File: rtl/scratch_vtiming.sv
// rtl/scratch_vtiming.sv - parametrised video timing generator for the Scratch core
// Purpose: derives pixel clock enables from clk, runs the raster counters, and produces
// sync, raw and delayed blanking, a frame strobe and blanked registered colour.
// Ports: clk (system clock), rst (synchronous active-high reset),
//        vid (scratch_vtiming_if.master: enables, raster, sync, blanking, colour in/out).
// Optional feature: SCRATCH_VTIMING_PATTERN_EN adds vid.pattern, which selects 8 vertical
// colour bars from hpos[7:5] in place of pxl_*.
module scratch_vtiming #(
  parameter int PXL_DIV   = 8,
  parameter int H_TOTAL   = 384,
  parameter int H_ACTIVE  = 256,
  parameter int HS_START  = 288,
  parameter int HS_LEN    = 32,
  parameter int V_TOTAL   = 264,
  parameter int V_ACTIVE  = 224,
  parameter int VS_START  = 240,
  parameter int VS_LEN    = 8,
  parameter int BLANK_DLY = 2,
  parameter int CW        = 4
) (
  input  logic              clk,
  input  logic              rst,
  scratch_vtiming_if.master vid
);
  localparam int               CNT_W    = $clog2(PXL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PXL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PXL_DIV / 2 - 1);
  localparam logic [8:0]       H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0]       V_LAST   = 9'(V_TOTAL - 1);
  // 10-bit limits so that totals of 512 and window ends at 512 stay representable.
  localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]       HS_BEG   = 10'(HS_START);
  localparam logic [9:0]       HS_END   = 10'(HS_START + HS_LEN);
  localparam logic [9:0]       VS_BEG   = 10'(VS_START);
  localparam logic [9:0]       VS_END   = 10'(VS_START + VS_LEN);

  if ((PXL_DIV < 4) || ((PXL_DIV % 2) != 0) ||
      (H_TOTAL > 512) || (V_TOTAL > 512) ||
      (H_ACTIVE > H_TOTAL) || (V_ACTIVE > V_TOTAL) ||
      ((HS_START + HS_LEN) > H_TOTAL) || ((VS_START + VS_LEN) > V_TOTAL) ||
      (BLANK_DLY < 0) || (BLANK_DLY > 15)) begin : g_param_check
    $error("scratch_vtiming: illegal timing parameters");
  end

  // ST_PRIME: after reset the outputs sit at zero until the first pixel enable,
  // which loads pixel (0,0) instead of advancing, so the first pixel carries frame.
  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [8:0]              h_nxt;
  logic [8:0]              v_nxt;
  logic                    hs_nxt;
  logic                    vs_nxt;
  logic                    frame_nxt;
  logic [1:0]              blank_nxt;   // {LHBL, LVBL} for the pixel being entered
  logic [1:0]              dly_nxt;     // {LHBL_dly, LVBL_dly} after this pixel edge
  logic [BLANK_DLY:0][1:0] bl;          // bl[k] is {LHBL, LVBL} delayed k pixels
  logic [CW-1:0]           r_src;
  logic [CW-1:0]           g_src;
  logic [CW-1:0]           b_src;

  always_comb begin
    cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    state_nxt = state;
    h_nxt     = vid.hpos;
    v_nxt     = vid.vpos;
    if (vid.pxl_cen) begin
      state_nxt = ST_RUN;
      if (state == ST_RUN) begin
        if (vid.hpos == H_LAST) begin
          h_nxt = '0;
          v_nxt = (vid.vpos == V_LAST) ? '0 : vid.vpos + 1'b1;
        end else begin
          h_nxt = vid.hpos + 1'b1;
        end
      end else begin
        h_nxt = '0;
        v_nxt = '0;
      end
    end
    blank_nxt = {({1'b0, h_nxt} < H_ACT), ({1'b0, v_nxt} < V_ACT)};
    hs_nxt    = ({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END);
    vs_nxt    = ({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END);
    frame_nxt = (h_nxt == 9'd0) && (v_nxt == 9'd0);
  end

  // The colour register must see the delayed blanking that becomes current on the
  // same edge, i.e. the value about to shift into the last tap.
  if (BLANK_DLY == 0) begin : g_dly0
    assign dly_nxt = blank_nxt;
  end else begin : g_dlyn
    assign dly_nxt = bl[BLANK_DLY-1];
  end

`ifdef SCRATCH_VTIMING_PATTERN_EN
  always_comb begin
    r_src = vid.pxl_red;
    g_src = vid.pxl_green;
    b_src = vid.pxl_blue;
    if (vid.pattern) begin
      r_src = {CW{h_nxt[7]}};
      g_src = {CW{h_nxt[6]}};
      b_src = {CW{h_nxt[5]}};
    end
  end
`else
  assign r_src = vid.pxl_red;
  assign g_src = vid.pxl_green;
  assign b_src = vid.pxl_blue;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_PRIME;
      cnt          <= '0;
      vid.pxl_cen  <= 1'b0;
      vid.pxl2_cen <= 1'b0;
      vid.hpos     <= '0;
      vid.vpos     <= '0;
      vid.HS       <= 1'b0;
      vid.VS       <= 1'b0;
      vid.frame    <= 1'b0;
      bl           <= '0;
      vid.red      <= '0;
      vid.green    <= '0;
      vid.blue     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      vid.pxl_cen  <= (cnt_nxt == CNT_LAST);
      vid.pxl2_cen <= (cnt_nxt == CNT_LAST) || (cnt_nxt == CNT_HALF);
      if (vid.pxl_cen) begin
        vid.hpos  <= h_nxt;
        vid.vpos  <= v_nxt;
        vid.HS    <= hs_nxt;
        vid.VS    <= vs_nxt;
        vid.frame <= frame_nxt;
        bl[0]     <= blank_nxt;
        for (int k = BLANK_DLY; k > 0; k--) begin
          bl[k] <= bl[k-1];
        end
        vid.red   <= (dly_nxt[1] & dly_nxt[0]) ? r_src : '0;
        vid.green <= (dly_nxt[1] & dly_nxt[0]) ? g_src : '0;
        vid.blue  <= (dly_nxt[1] & dly_nxt[0]) ? b_src : '0;
      end
    end
  end

  assign vid.LHBL     = bl[0][1];
  assign vid.LVBL     = bl[0][0];
  assign vid.LHBL_dly = bl[BLANK_DLY][1];
  assign vid.LVBL_dly = bl[BLANK_DLY][0];
endmodule
